// File: rtl/perf_counters_pkg.sv
// Shared constants for the performance counters and the stage-3 IO read mux.
// The mux decodes the counter addresses from here, so both sides agree on the map.
package perf_counters_pkg;

  localparam logic [4:0]  BRANCH_OPC       = 5'b11000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

  localparam logic [31:0] CYC_ADDR         = 32'h8000_0010;
  localparam logic [31:0] INSTR_ADDR       = 32'h8000_0014;
  localparam logic [31:0] CLR_ADDR         = 32'h8000_0018;
  localparam logic [31:0] BR_INSTR_ADDR    = 32'h8000_001c;
  localparam logic [31:0] CORRECT_BR_ADDR  = 32'h8000_0020;

endpackage

// File: rtl/perf_counters_event_counter.sv
// Wrapping event counter: a synchronous clear beats an increment in the same cycle.
module event_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/perf_counters.sv
// Cycle, retired-instruction and branch-prediction counters for the 3-stage core.
// Branch outcomes are captured in stage 2 and committed one advance later, at retirement.
module perf_counters
  import perf_counters_pkg::*;
#(
  parameter int          WIDTH     = 32,
  parameter logic [31:0] NOP_INSTR = perf_counters_pkg::NOP_INSTR,
  parameter logic [31:0] CLR_ADDR  = perf_counters_pkg::CLR_ADDR
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             valid_s2,
  input  logic [31:0]      instruction_s2,
  input  logic             br_taken_s2,
  input  logic             br_pred_taken_s2,
  input  logic             valid_s3,
  input  logic [31:0]      instruction_s3,
  input  logic [31:0]      mem_addr,
  input  logic             mem_we,
  output logic [WIDTH-1:0] cyc_counter,
  output logic [WIDTH-1:0] instr_counter,
  output logic [WIDTH-1:0] br_instr_counter,
  output logic [WIDTH-1:0] correct_br_counter
);

  logic adv;
  logic clr;
  logic is_branch_s2;
  logic instr_inc;
  logic br_inc;
  logic correct_inc;
  logic br_evt_v;
  logic br_evt_ok;
  logic unused_s2_bits;

  assign adv          = !stall;
  assign clr          = adv && mem_we && (mem_addr == CLR_ADDR);
  assign is_branch_s2 = valid_s2 && (instruction_s2[6:2] == BRANCH_OPC);

  // Only the major-opcode field of the stage-2 word matters for classification.
  assign unused_s2_bits = ^{instruction_s2[31:7], instruction_s2[1:0]};

  assign instr_inc   = adv && valid_s3 && (instruction_s3 != NOP_INSTR);
  assign br_inc      = adv && br_evt_v;
  assign correct_inc = adv && br_evt_v && br_evt_ok;

  // Pending event travels with the branch from stage 2 into stage 3; held on stall.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      br_evt_v  <= 1'b0;
      br_evt_ok <= 1'b0;
    end else if (clr) begin
      br_evt_v  <= 1'b0;
      br_evt_ok <= 1'b0;
    end else if (adv) begin
      br_evt_v  <= is_branch_s2;
      br_evt_ok <= (br_taken_s2 == br_pred_taken_s2);
    end
  end

  event_counter #(.WIDTH(WIDTH)) u_cyc (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .inc   (1'b1),
    .count (cyc_counter)
  );

  event_counter #(.WIDTH(WIDTH)) u_instr (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .inc   (instr_inc),
    .count (instr_counter)
  );

  event_counter #(.WIDTH(WIDTH)) u_br (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .inc   (br_inc),
    .count (br_instr_counter)
  );

  event_counter #(.WIDTH(WIDTH)) u_correct (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .inc   (correct_inc),
    .count (correct_br_counter)
  );

endmodule

// File: tb/tb_perf_counters.sv
// Directed bench for perf_counters: a 32-bit instance for function, an 8-bit one for wrap.
module tb_perf_counters;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] ADDI = 32'h0010_8093;
  localparam logic [31:0] BEQ  = 32'h0020_8063;
  localparam logic [31:0] BNE  = 32'h0020_9063;
  localparam logic [31:0] JAL  = 32'h0000_006f;
  localparam logic [31:0] SW   = 32'h0020_a023;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        valid_s2;
  logic [31:0] instruction_s2;
  logic        br_taken_s2;
  logic        br_pred_taken_s2;
  logic        valid_s3;
  logic [31:0] instruction_s3;
  logic [31:0] mem_addr;
  logic        mem_we;

  logic [31:0] cyc_counter;
  logic [31:0] instr_counter;
  logic [31:0] br_instr_counter;
  logic [31:0] correct_br_counter;
  logic [7:0]  cyc8;
  logic [7:0]  instr8;
  logic [7:0]  br8;
  logic [7:0]  correct8;

  int checks;
  int errors;
  int exp_cyc;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  perf_counters #(.WIDTH(32)) dut (
    .clk                (clk),
    .rst                (rst),
    .stall              (stall),
    .valid_s2           (valid_s2),
    .instruction_s2     (instruction_s2),
    .br_taken_s2        (br_taken_s2),
    .br_pred_taken_s2   (br_pred_taken_s2),
    .valid_s3           (valid_s3),
    .instruction_s3     (instruction_s3),
    .mem_addr           (mem_addr),
    .mem_we             (mem_we),
    .cyc_counter        (cyc_counter),
    .instr_counter      (instr_counter),
    .br_instr_counter   (br_instr_counter),
    .correct_br_counter (correct_br_counter)
  );

  perf_counters #(.WIDTH(8)) dut8 (
    .clk                (clk),
    .rst                (rst),
    .stall              (stall),
    .valid_s2           (valid_s2),
    .instruction_s2     (instruction_s2),
    .br_taken_s2        (br_taken_s2),
    .br_pred_taken_s2   (br_pred_taken_s2),
    .valid_s3           (valid_s3),
    .instruction_s3     (instruction_s3),
    .mem_addr           (mem_addr),
    .mem_we             (mem_we),
    .cyc_counter        (cyc8),
    .instr_counter      (instr8),
    .br_instr_counter   (br8),
    .correct_br_counter (correct8)
  );

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", tag, got, got, exp, exp);
    end
  endtask

  // ---------------- drivers ----------------
  // Advance n rising edges, then settle 1 time unit past the edge for driving/sampling.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      exp_cyc++;
    end
    #1;
  endtask

  task automatic drive_s2(input logic v, input logic [31:0] ins, input logic taken, input logic pred);
    valid_s2         = v;
    instruction_s2   = ins;
    br_taken_s2      = taken;
    br_pred_taken_s2 = pred;
  endtask

  task automatic drive_s3(input logic v, input logic [31:0] ins, input logic we, input logic [31:0] addr);
    valid_s3       = v;
    instruction_s3 = ins;
    mem_we         = we;
    mem_addr       = addr;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    checks  = 0;
    errors  = 0;
    exp_cyc = 0;
    rst     = 1'b0;
    stall   = 1'b0;
    drive_s2(1'b0, NOP, 1'b0, 1'b0);
    drive_s3(1'b1, NOP, 1'b0, 32'h0);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_cyc", cyc_counter, 32'd0);
    check("rst_instr", instr_counter, 32'd0);
    check("rst_br", br_instr_counter, 32'd0);
    check("rst_correct", correct_br_counter, 32'd0);

    // 100 cycles of bubbles retiring
    rst     = 1'b1;
    exp_cyc = 0;
    tick(100);
    check("idle_cyc", cyc_counter, 32'd100);
    check("idle_cyc8", {24'd0, cyc8}, 32'd100);
    check("idle_instr", instr_counter, 32'd0);

    // 10 addi retiring, then 2 cycles with the slot flagged invalid
    drive_s3(1'b1, ADDI, 1'b0, 32'h0);
    tick(10);
    check("addi_instr", instr_counter, 32'd10);
    check("addi_br", br_instr_counter, 32'd0);
    check("addi_correct", correct_br_counter, 32'd0);
    drive_s3(1'b0, ADDI, 1'b0, 32'h0);
    tick(2);
    check("invalid_s3_instr", instr_counter, 32'd10);
    drive_s3(1'b1, NOP, 1'b0, 32'h0);

    // Mispredicted beq, then correctly predicted bne
    drive_s2(1'b1, BEQ, 1'b1, 1'b0);
    tick(1);
    check("beq_handoff_br", br_instr_counter, 32'd0);
    drive_s2(1'b1, BNE, 1'b0, 1'b0);
    tick(1);
    check("beq_retire_br", br_instr_counter, 32'd1);
    check("beq_retire_correct", correct_br_counter, 32'd0);
    drive_s2(1'b0, NOP, 1'b0, 1'b0);
    tick(1);
    check("bne_retire_br", br_instr_counter, 32'd2);
    check("bne_retire_correct", correct_br_counter, 32'd1);

    // JAL is not a branch
    drive_s2(1'b1, JAL, 1'b1, 1'b0);
    tick(2);
    drive_s2(1'b0, NOP, 1'b0, 1'b0);
    tick(1);
    check("jal_br", br_instr_counter, 32'd2);
    check("jal_correct", correct_br_counter, 32'd1);

    // beq held in s2 under stall for 5 cycles
    drive_s2(1'b1, BEQ, 1'b1, 1'b1);
    stall = 1'b1;
    tick(5);
    check("stall_cyc", cyc_counter, exp_cyc[31:0]);
    check("stall_br", br_instr_counter, 32'd2);
    check("stall_correct", correct_br_counter, 32'd1);
    stall = 1'b0;
    tick(1);
    check("stall_handoff_br", br_instr_counter, 32'd2);
    // Pending event held across a stall in stage 3
    drive_s2(1'b0, NOP, 1'b0, 1'b0);
    stall = 1'b1;
    tick(3);
    check("pend_stall_br", br_instr_counter, 32'd2);
    stall = 1'b0;
    tick(1);
    check("pend_retire_br", br_instr_counter, 32'd3);
    check("pend_retire_correct", correct_br_counter, 32'd2);
    tick(1);
    check("pend_no_double", br_instr_counter, 32'd3);

    // Store to a non-clear address has no effect
    drive_s2(1'b1, BEQ, 1'b0, 1'b0);
    tick(1);
    drive_s2(1'b0, NOP, 1'b0, 1'b0);
    drive_s3(1'b1, SW, 1'b1, 32'h8000_0014);
    tick(1);
    check("noclr_br", br_instr_counter, 32'd4);
    check("noclr_instr", instr_counter, 32'd11);
    check("noclr_cyc", cyc_counter, exp_cyc[31:0]);

    // Clearing store retiring with a pending branch event
    drive_s3(1'b1, NOP, 1'b0, 32'h0);
    drive_s2(1'b1, BEQ, 1'b1, 1'b1);
    tick(1);
    drive_s2(1'b0, NOP, 1'b0, 1'b0);
    drive_s3(1'b1, SW, 1'b1, 32'h8000_0018);
    tick(1);
    exp_cyc = 0;
    check("clr_cyc", cyc_counter, 32'd0);
    check("clr_instr", instr_counter, 32'd0);
    check("clr_br", br_instr_counter, 32'd0);
    check("clr_correct", correct_br_counter, 32'd0);
    drive_s3(1'b1, NOP, 1'b0, 32'h0);
    tick(1);
    check("post_clr_cyc", cyc_counter, 32'd1);
    check("post_clr_br", br_instr_counter, 32'd0);
    check("post_clr_correct", correct_br_counter, 32'd0);

    // 8-bit wrap: 255 more edges takes cyc8 from 1 to 0
    tick(255);
    check("wrap_cyc8", {24'd0, cyc8}, 32'd0);
    check("wrap_cyc32", cyc_counter, 32'd256);

    // Asynchronous reset pulse mid-cycle
    tick(3);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_cyc", cyc_counter, 32'd0);
    check("async_rst_cyc8", {24'd0, cyc8}, 32'd0);
    check("async_rst_br", br_instr_counter, 32'd0);
    @(posedge clk);
    #1;
    check("rst_hold_cyc", cyc_counter, 32'd0);
    rst     = 1'b1;
    exp_cyc = 0;
    tick(1);
    check("rst_release_cyc", cyc_counter, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
